// File: rtl/lab20_priority_encoder.sv
// Registered N-to-log2(N) encoder with strict/MSB/LSB/round-robin modes; 1-cycle latency.
// in_ready drops only while a result is held and out_ready=0; the held result stays frozen.
module lab20_priority_encoder #(
  parameter int DATA_SIZE = 2,
  parameter int CNT_W     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [(1<<DATA_SIZE)-1:0]  i,
  input  logic [1:0]                 mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_SIZE-1:0]       y,
  output logic                       flag_valid,
  output logic                       multi_hot,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       err_clr,
  output logic [CNT_W-1:0]           err_cnt
);

  localparam int N = 1 << DATA_SIZE;

  localparam logic [1:0] MODE_STRICT = 2'd0;
  localparam logic [1:0] MODE_MSB    = 2'd1;
  localparam logic [1:0] MODE_LSB    = 2'd2;
  localparam logic [1:0] MODE_RR     = 2'd3;

  logic                 out_valid_q, out_valid_d;
  logic [DATA_SIZE-1:0] y_q, y_d;
  logic                 flag_q, flag_d;
  logic                 multi_q, multi_d;
  logic [DATA_SIZE-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]     err_q, err_d;

  logic [DATA_SIZE:0]   popcnt;
  logic [DATA_SIZE-1:0] msb_idx;
  logic [DATA_SIZE-1:0] lsb_idx;
  logic [DATA_SIZE-1:0] rr_idx;
  logic [DATA_SIZE-1:0] rr_probe;
  logic                 any_set;
  logic                 accept;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign any_set  = |i;

  // Index scans: ascending loop leaves the highest set bit, descending the lowest.
  always_comb begin
    popcnt   = '0;
    msb_idx  = '0;
    lsb_idx  = '0;
    rr_idx   = '0;
    rr_probe = '0;
    for (int j = 0; j < N; j++) begin
      popcnt = popcnt + (DATA_SIZE+1)'(i[j]);
      if (i[j]) msb_idx = DATA_SIZE'(j);
    end
    for (int j = N-1; j >= 0; j--) begin
      if (i[j]) lsb_idx = DATA_SIZE'(j);
    end
    // Walk ptr+N-1 down to ptr so the final hit is the first one in search order.
    for (int j = N-1; j >= 0; j--) begin
      rr_probe = ptr_q + DATA_SIZE'(j);
      if (i[rr_probe]) rr_idx = rr_probe;
    end
  end

  always_comb begin
    y_d         = y_q;
    flag_d      = flag_q;
    multi_d     = multi_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    err_d       = err_q;

    if (accept) begin
      out_valid_d = 1'b1;
      multi_d     = (popcnt >= (DATA_SIZE+1)'(2));
      y_d         = '0;
      flag_d      = 1'b0;
      case (mode)
        MODE_STRICT: begin
          if (popcnt == (DATA_SIZE+1)'(1)) begin
            y_d    = lsb_idx;
            flag_d = 1'b1;
          end
        end
        MODE_MSB: begin
          if (any_set) begin
            y_d    = msb_idx;
            flag_d = 1'b1;
          end
        end
        MODE_LSB: begin
          if (any_set) begin
            y_d    = lsb_idx;
            flag_d = 1'b1;
          end
        end
        MODE_RR: begin
          if (any_set) begin
            y_d    = rr_idx;
            flag_d = 1'b1;
            ptr_d  = rr_idx + DATA_SIZE'(1);
          end
        end
        default: ;
      endcase
      if (!flag_d && (err_q != '1)) err_d = err_q + CNT_W'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (err_clr) err_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      flag_q      <= 1'b0;
      multi_q     <= 1'b0;
      ptr_q       <= '0;
      err_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      flag_q      <= flag_d;
      multi_q     <= multi_d;
      ptr_q       <= ptr_d;
      err_q       <= err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign y          = y_q;
  assign flag_valid = flag_q;
  assign multi_hot  = multi_q;
  assign err_cnt    = err_q;

endmodule

// File: doc/lab20_priority_encoder.md
# lab20_priority_encoder

Registered, parametrised N-to-log2(N) encoder (N = 2**DATA_SIZE) with four run-time selectable encode modes: strict one-hot, MSB-priority, LSB-priority and round-robin. Requests enter on a valid/ready handshake. Results leave one cycle later on a valid/ready handshake, with a no-match flag, a multi-hot flag and a saturating error counter. It is the generalised, pipelined successor to the lab 4-to-2 combinational encoder and feeds arbitration and interrupt-select logic downstream.

## Interface
- DATA_SIZE, 2, encoded output width; input vector width N = 2**DATA_SIZE (legal 1..6)
- CNT_W, 8, width of the error counter
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- i  input  N  request vector
- mode  input  2  encode mode: 0 strict one-hot, 1 MSB priority, 2 LSB priority, 3 round-robin
- in_valid  input  1  request present
- in_ready  output  1  block can accept the request this cycle
- y  output  DATA_SIZE  encoded index of the selected bit
- flag_valid  output  1  a bit was selected (result meaningful)
- multi_hot  output  1  two or more bits of i were set
- out_valid  output  1  result registers hold an unconsumed result
- out_ready  input  1  downstream consumes the result
- err_clr  input  1  synchronous clear of err_cnt
- err_cnt  output  CNT_W  count of accepted requests with flag_valid=0, saturating

## Operation
- Accept occurs when in_valid && in_ready. mode and i are sampled only at accept.
- Mode 0, strict: exactly one bit k set -> y=k, flag_valid=1. Any other pattern (zero or multi-hot) -> y=0, flag_valid=0.
- Mode 1, MSB: y = highest set index, flag_valid=1. If i==0 -> y=0, flag_valid=0.
- Mode 2, LSB: y = lowest set index, flag_valid=1. If i==0 -> y=0, flag_valid=0.
- Mode 3, round-robin:
  - Internal pointer ptr (DATA_SIZE bits, reset 0).
  - Search indices ptr, ptr+1, ..., N-1, 0, ..., ptr-1. The first set index k gives y=k, flag_valid=1, and ptr <= (k+1) mod N, wrapping N-1 -> 0.
  - If i==0: y=0, flag_valid=0, ptr unchanged.
- ptr changes only on an accept in mode 3. Accepts in other modes leave ptr unchanged.
- multi_hot = (popcount(i) >= 2) in every mode, registered alongside y.
- err_cnt:
  - +1 on each accept whose result has flag_valid=0, in any mode.
  - Saturates at 2**CNT_W-1.
  - err_clr forces 0 on the next edge and wins over a simultaneous increment.
- Arithmetic: ptr wraps modulo N. err_cnt never wraps.

## Timing
- Reset values (async assert, sync-safe deassert): out_valid=0, y=0, flag_valid=0, multi_hot=0, err_cnt=0, ptr=0.
- in_ready = !out_valid || out_ready (combinational). It is 1 out of reset.
- Latency: an accept at edge t drives out_valid=1 with the result from edge t, visible in cycle t+1.
- Throughput: one result per cycle while out_ready=1.
- Backpressure: while out_valid && !out_ready, y, flag_valid, multi_hot and out_valid hold stable, and no accept occurs.
- Consume with no accept in the same cycle -> out_valid <= 0. Consume with an accept in the same cycle -> new result loaded, out_valid stays 1.
- Reset mid-transaction drops any pending result. ptr and err_cnt return to 0.
- A mode change between accepts is legal. It takes effect at the next accept, and ptr is retained across mode changes.

## Test plan
- Reset/idle: assert rst_n=0 mid-stream with out_valid=1 -> all outputs 0 immediately, in_ready=1 after release.
- Strict, DATA_SIZE=2: i=1000, 0100, 0010, 0001, 0110, 0000 back-to-back, out_ready=1 -> y=3,2,1,0,0,0; flag_valid=1,1,1,1,0,0; multi_hot only on 0110; err_cnt=2.
- Priority, DATA_SIZE=3: i=8'b0101_0010 -> mode 1 gives y=6, mode 2 gives y=1, both flag_valid=1 and multi_hot=1.
- Round-robin, DATA_SIZE=2: i=1011 for four accepts -> y=0,1,3,0 with ptr 1,2,0,1. Then i=0000 -> flag_valid=0, ptr stays 1.
- Backpressure: out_ready=0 for 3 cycles after a result -> y stable, in_ready=0, no ptr/err_cnt change. Release out_ready with in_valid=1 -> accept in the same cycle, out_valid stays 1.
- Counter: CNT_W=2, five accepts with i=0 -> err_cnt=1,2,3,3,3. Then err_clr coincident with a failing accept -> err_cnt=0.
